// File: rtl/fp_operate_pipe_if.sv
// ---------------------------------------------------------------------------
// fp_operate_pipe_if
//   Bundles the upstream (compare/swap -> operate) and downstream
//   (operate -> normalize/round) beats of the FP add/sub operate stage.
//
//   Handshake: a beat moves on a side in the cycle where valid and ready are
//   both 1 at the rising clock edge. A producer holding valid=1 keeps its
//   payload stable until the transfer, and ready may depend combinationally
//   on the consumer's own downstream ready.
//
//   Ports (slave = operate stage view):
//     in_valid/in_ready, op, flip, dst, gt_sign/gt_exp/gt_mnt,
//     lt_sign/lt_mnt, e_dif                      - upstream beat
//     out_valid/out_ready, out_op, out_flip, out_dst, out_sign, out_exp,
//     out_mnt {carry, mantissa, guard, round, sticky}, out_zero
//                                                - downstream beat
// ---------------------------------------------------------------------------
interface fp_operate_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MNT_W = 24,
    parameter int DST_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic               op;
    logic               flip;
    logic [DST_W-1:0]   dst;
    logic               gt_sign;
    logic [EXP_W-1:0]   gt_exp;
    logic [MNT_W-1:0]   gt_mnt;
    logic               lt_sign;
    logic [MNT_W-1:0]   lt_mnt;
    logic [EXP_W-1:0]   e_dif;

    logic               out_valid;
    logic               out_ready;
    logic               out_op;
    logic               out_flip;
    logic [DST_W-1:0]   out_dst;
    logic               out_sign;
    logic [EXP_W-1:0]   out_exp;
    logic [MNT_W+3:0]   out_mnt;
    logic               out_zero;

    modport slave (
        input  in_valid, op, flip, dst, gt_sign, gt_exp, gt_mnt,
               lt_sign, lt_mnt, e_dif, out_ready,
        output in_ready, out_valid, out_op, out_flip, out_dst,
               out_sign, out_exp, out_mnt, out_zero
    );

    modport master (
        output in_valid, op, flip, dst, gt_sign, gt_exp, gt_mnt,
               lt_sign, lt_mnt, e_dif, out_ready,
        input  in_ready, out_valid, out_op, out_flip, out_dst,
               out_sign, out_exp, out_mnt, out_zero
    );
endinterface

// File: rtl/fp_operate_pipe.sv
// ---------------------------------------------------------------------------
// fp_operate_pipe
//   Two-stage operate stage of the FP add/subtract datapath.
//   Stage 1 aligns the smaller mantissa by e_dif keeping guard/round/sticky;
//   stage 2 adds or subtracts the extended mantissas.
//
//   Ports:
//     clk    - clock
//     reset  - asynchronous active-high reset
//     bus    - fp_operate_pipe_if.slave (upstream and downstream beats)
// ---------------------------------------------------------------------------
module fp_operate_pipe #(
    parameter int EXP_W = 8,
    parameter int MNT_W = 24,
    parameter int DST_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    fp_operate_pipe_if.slave  bus
);
    localparam int EXT_W = MNT_W + 3;   // mantissa + guard/round/sticky
    localparam int SUM_W = MNT_W + 4;   // plus carry

    // Stage 1 registers
    logic               r_v1;
    logic               r_s1_action;
    logic               r_s1_op;
    logic               r_s1_flip;
    logic [DST_W-1:0]   r_s1_dst;
    logic               r_s1_sign;
    logic [EXP_W-1:0]   r_s1_exp;
    logic [EXT_W-1:0]   r_s1_gt_ext;
    logic [EXT_W-1:0]   r_s1_lt_ext;

    // Stage 2 registers
    logic               r_v2;
    logic               r_s2_op;
    logic               r_s2_flip;
    logic [DST_W-1:0]   r_s2_dst;
    logic               r_s2_sign;
    logic [EXP_W-1:0]   r_s2_exp;
    logic [SUM_W-1:0]   r_s2_mnt;
    logic               r_s2_zero;

    logic               w_adv1;
    logic               w_adv2;
    logic [EXT_W-1:0]   w_lt_full;
    logic [EXT_W-1:0]   w_lt_shr;
    logic [EXT_W-1:0]   w_lost_mask;
    logic [EXT_W-1:0]   w_lt_ext;
    logic [SUM_W-1:0]   w_res;

    // A stage advances when it is empty or the stage after it advances,
    // so a full pipe can accept and drain in the same cycle.
    assign w_adv2       = !r_v2 || bus.out_ready;
    assign w_adv1       = !r_v1 || w_adv2;
    assign bus.in_ready = w_adv1;

    // Alignment: every bit shifted off the bottom folds into the sticky bit.
    // Shifts at or beyond the extended width leave only "was lt nonzero".
    always_comb begin
        w_lt_full   = {bus.lt_mnt, 3'b000};
        w_lt_shr    = w_lt_full >> bus.e_dif;
        w_lost_mask = ~({EXT_W{1'b1}} << bus.e_dif);
        if (32'(bus.e_dif) >= 32'(EXT_W)) begin
            w_lt_ext = {{(EXT_W-1){1'b0}}, |bus.lt_mnt};
        end else begin
            w_lt_ext = {w_lt_shr[EXT_W-1:1],
                        w_lt_shr[0] | (|(w_lt_full & w_lost_mask))};
        end
    end

    // Upstream guarantees |gt| >= |lt|, so the subtract never borrows.
    always_comb begin
        if (r_s1_action) begin
            w_res = {1'b0, r_s1_gt_ext} - {1'b0, r_s1_lt_ext};
        end else begin
            w_res = {1'b0, r_s1_gt_ext} + {1'b0, r_s1_lt_ext};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1        <= 1'b0;
            r_s1_action <= 1'b0;
            r_s1_op     <= 1'b0;
            r_s1_flip   <= 1'b0;
            r_s1_dst    <= '0;
            r_s1_sign   <= 1'b0;
            r_s1_exp    <= '0;
            r_s1_gt_ext <= '0;
            r_s1_lt_ext <= '0;
        end else if (w_adv1) begin
            r_v1        <= bus.in_valid;
            r_s1_action <= bus.gt_sign ^ bus.lt_sign ^ bus.op;
            r_s1_op     <= bus.op;
            r_s1_flip   <= bus.flip;
            r_s1_dst    <= bus.dst;
            r_s1_sign   <= bus.gt_sign;
            r_s1_exp    <= bus.gt_exp;
            r_s1_gt_ext <= {bus.gt_mnt, 3'b000};
            r_s1_lt_ext <= w_lt_ext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v2      <= 1'b0;
            r_s2_op   <= 1'b0;
            r_s2_flip <= 1'b0;
            r_s2_dst  <= '0;
            r_s2_sign <= 1'b0;
            r_s2_exp  <= '0;
            r_s2_mnt  <= '0;
            r_s2_zero <= 1'b0;
        end else if (w_adv2) begin
            r_v2      <= r_v1;
            r_s2_op   <= r_s1_op;
            r_s2_flip <= r_s1_flip;
            r_s2_dst  <= r_s1_dst;
            r_s2_sign <= r_s1_sign;
            r_s2_exp  <= r_s1_exp;
            r_s2_mnt  <= w_res;
            r_s2_zero <= (w_res == '0);
        end
    end

    assign bus.out_valid = r_v2;
    assign bus.out_op    = r_s2_op;
    assign bus.out_flip  = r_s2_flip;
    assign bus.out_dst   = r_s2_dst;
    assign bus.out_sign  = r_s2_sign;
    assign bus.out_exp   = r_s2_exp;
    assign bus.out_mnt   = r_s2_mnt;
    assign bus.out_zero  = r_s2_zero;
endmodule

// File: doc/fp_operate_pipe.md
# fp_operate_pipe

Parametrised, two-stage pipelined operate stage of the floating-point add/subtract datapath. Aligns the smaller operand's mantissa to the larger using the precomputed exponent difference, with guard/round/sticky retention, then adds or subtracts the extended mantissas. It sits between the compare/swap stage and the normalize/round stage, with valid/ready handshakes on both sides.

## Interface
- EXP_W, 8, exponent width; also the width of e_dif
- MNT_W, 24, mantissa width including the hidden bit
- DST_W, 5, width of the pass-through destination tag
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat present
- in_ready  out  1  stage can accept an input beat this cycle
- op  in  1  0 = add, 1 = subtract
- flip  in  1  operands were swapped upstream (pass-through)
- dst  in  DST_W  destination tag (pass-through)
- gt_sign, gt_exp, gt_mnt  in  1/EXP_W/MNT_W  larger-magnitude operand
- lt_sign, lt_mnt  in  1/MNT_W  smaller-magnitude operand
- e_dif  in  EXP_W  gt_exp - lt_exp, unsigned
- out_valid  out  1  result beat present
- out_ready  in  1  downstream accepts the beat
- out_op, out_flip, out_dst  out  1/1/DST_W  pass-through fields
- out_sign, out_exp  out  1/EXP_W  gt_sign and gt_exp, registered
- out_mnt  out  MNT_W+4  {carry, result[MNT_W-1:0], guard, round, sticky}
- out_zero  out  1  out_mnt == 0

## Operation
- Stage 1 (align), registered:
  - gt_ext = {gt_mnt, 3'b000}
  - lt_ext = {lt_mnt, 3'b000} >> e_dif, then bit 0 |= OR of every bit shifted out
  - If e_dif >= MNT_W+3: lt_ext = {(MNT_W+2)'b0, |lt_mnt}
  - Capture the action bit = gt_sign ^ lt_sign ^ op, plus all pass-through fields.
- Stage 2 (operate), registered:
  - action 0: out_mnt = gt_ext + lt_ext, zero-extended to MNT_W+4
  - action 1: out_mnt = gt_ext - lt_ext. Upstream guarantees |gt| >= |lt|, so no borrow occurs.
  - out_zero = (out_mnt == 0). out_sign is gt_sign unmodified; the normalize stage resolves the sign of a zero result.
- Each stage holds one beat with a valid bit (v1, v2).
- Handshake:
  - adv2 = !v2 | out_ready
  - adv1 = !v1 | adv2
  - in_ready = adv1, combinational from out_ready.
  - A beat transfers on in_valid & in_ready, and on out_valid & out_ready.
- The pipeline is fully streaming: one beat per cycle at steady state with no bubbles.

## Timing
- Latency: an input accepted in cycle N appears on out_valid in cycle N+2 if not stalled.
- While out_valid & !out_ready, all out_* fields are held bit-stable.
- Under a stall, stage 1 still accepts one beat if v1 = 0, then in_ready falls. There is no loss and no duplication.
- Simultaneous accept and drain with the pipeline full: both stages advance in the same cycle and in_ready stays 1.
- Reset (asynchronous, any time, including mid-stall): v1 = v2 = 0, out_valid = 0, and every datapath register = 0 (out_mnt = 0, out_zero = 0, out_sign = 0, out_exp = 0, out_op/out_flip/out_dst = 0).
- in_ready = 1 during and immediately after reset.
- The datapath registers of a stage load only when that stage advances; its contents are don't-care when its valid bit is 0.

## Test plan
All cases use EXP_W=8, MNT_W=24.
- Add, e_dif=1: gt_mnt=24'h800000, lt_mnt=24'h800000, signs equal, op=0 -> out_mnt=28'h6000000, out_valid two cycles after accept.
- Sticky, e_dif=5: gt_mnt=24'h800000, lt_mnt=24'h000001, signs equal, op=1 -> lt_ext=27'h0000001, out_mnt=28'h3FFFFFF.
- Large shift, e_dif=200: lt_mnt=24'h123456, add -> lt_ext=27'h1, out_mnt=28'h4000001. Repeat with lt_mnt=0 -> out_mnt=28'h4000000.
- Exact cancel, e_dif=0: equal mantissas, opposite signs, op=0 -> out_mnt=0, out_zero=1, out_sign=gt_sign.
- Backpressure, 8 back-to-back beats with random values:
  - Hold out_ready=0 for 4 cycles: in_ready falls after 2 beats are held, outputs stay stable.
  - Release: all 8 results arrive in order and match a reference model.
- Reset mid-stream: assert reset with v1=v2=1 -> out_valid=0 immediately (asynchronously), in_ready=1. The first post-reset beat is produced with correct latency.
